// File: rtl/dev_sigmoid_deriv.sv
`default_nettype none
// ============================================================================
// Module   : dev_sigmoid_deriv
// Function : Piecewise-linear sigmoid derivative y*(1-y) on signed Q8.12 data.
//            Define DEV_PIPE_EN to register y before the multiply (2-cycle latency).
// Revision : 1.0  initial release
// ============================================================================
module dev_sigmoid_deriv #(
   parameter int WIDTH = 20,
   parameter int FRAC  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] SP_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] D_out
);

   // y never exceeds 1.0, so FRAC+1 bits hold it exactly
   localparam int               c_yw   = FRAC + 1;
   localparam logic [c_yw-1:0]  c_one  = c_yw'(1 << FRAC);
   localparam logic [WIDTH-1:0] c_seg1 = WIDTH'(4096);
   localparam logic [WIDTH-1:0] c_seg2 = WIDTH'(9728);
   localparam logic [WIDTH-1:0] c_seg3 = WIDTH'(20480);
   localparam logic [WIDTH-1:0] c_amin = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] c_amax = {1'b0, {(WIDTH-1){1'b1}}};

   logic               w_neg;
   logic [WIDTH-1:0]   w_abs;
   logic [c_yw-1:0]    w_ya;
   logic [c_yw-1:0]    w_y;
   logic [c_yw-1:0]    w_ys;
   logic               w_vs;
   logic [c_yw-1:0]    w_ym;
   logic [2*c_yw-1:0]  w_prod;
   logic [WIDTH-1:0]   w_d;

   always_comb begin
      w_neg = SP_out[WIDTH-1];
      w_abs = SP_out;
      if (w_neg) begin
         // the most negative code has no positive twin, so clamp it
         if (SP_out == c_amin) w_abs = c_amax;
         else                  w_abs = ~SP_out + 1'b1;
      end
   end

   always_comb begin
      w_ya = c_one;
      if (w_abs >= c_seg3)      w_ya = c_one;
      else if (w_abs >= c_seg2) w_ya = c_yw'(w_abs >> 5) + c_yw'(3456);
      else if (w_abs >= c_seg1) w_ya = c_yw'(w_abs >> 3) + c_yw'(2560);
      else                      w_ya = c_yw'(w_abs >> 2) + c_yw'(2048);
      w_y = w_neg ? (c_one - w_ya) : w_ya;
   end

`ifdef DEV_PIPE_EN
   logic [c_yw-1:0] r_y;
   logic            r_v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y  <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) r_y <= w_y;
      end
   end

   assign w_ys = r_y;
   assign w_vs = r_v1;
`else
   assign w_ys = w_y;
   assign w_vs = in_valid;
`endif

   assign w_ym   = c_one - w_ys;
   assign w_prod = (2*c_yw)'(w_ys) * (2*c_yw)'(w_ym);
   assign w_d    = WIDTH'(w_prod >> FRAC);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         D_out     <= '0;
      end else begin
         out_valid <= w_vs;
         if (w_vs) D_out <= w_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dev_sigmoid_deriv.sv
`default_nettype none
// ============================================================================
// Module   : tb_dev_sigmoid_deriv
// Function : Self-checking bench for dev_sigmoid_deriv (either DEV_PIPE_EN build).
// Revision : 1.0  initial release
// ============================================================================
module tb_dev_sigmoid_deriv;

`ifdef DEV_PIPE_EN
   localparam int c_lat = 2;
`else
   localparam int c_lat = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [19:0] sp;
   logic        out_valid;
   logic [19:0] d_out;

   int n_vec = 0;
   int n_bad = 0;

   int hist_rst[$];
   int hist_v[$];
   int hist_x[$];
   int exp_d = 0;
   int exp_v = 0;
   bit cap_en = 1'b0;
   int capq[$];

   typedef struct {
      logic [19:0] x;
      int          d;
   } vec_t;
   vec_t tbl[14];

   dev_sigmoid_deriv #(.WIDTH(20), .FRAC(12)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .SP_out   (sp),
      .out_valid(out_valid),
      .D_out    (d_out)
   );

   always #5 clk = ~clk;

   // Reference: evaluate y(x) from the piecewise rules, then y*(1-y) in integer arithmetic
   function automatic int ref_d(input logic [19:0] x);
      int xs, a, y;
      xs = $signed(x);
      a  = (xs < 0) ? -xs : xs;
      if (a > 524287) a = 524287;
      if (a >= 20480)     y = 4096;
      else if (a >= 9728) y = a / 32 + 3456;
      else if (a >= 4096) y = a / 8 + 2560;
      else                y = a / 4 + 2048;
      if (xs < 0) y = 4096 - y;
      return (y * (4096 - y)) / 4096;
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // One clock edge: record the inputs seen there, advance the model, compare outputs.
   task automatic step();
      int n, s;
      bit rwin;
      @(posedge clk);
      hist_rst.push_back(int'(rst));
      hist_v.push_back(int'(in_valid));
      hist_x.push_back(int'(sp));
      n    = hist_rst.size() - 1;
      s    = n - c_lat + 1;
      rwin = 1'b0;
      for (int k = (s < 0 ? 0 : s); k <= n; k++)
         if (hist_rst[k] != 0) rwin = 1'b1;
      exp_v = (s >= 0 && !rwin && hist_v[s] != 0) ? 1 : 0;
      if (exp_v != 0)           exp_d = ref_d(20'(hist_x[s]));
      else if (hist_rst[n] != 0) exp_d = 0;
      #1;
      check("out_valid", int'(out_valid), exp_v);
      check("D_out", int'(d_out), exp_d);
      if (cap_en && out_valid) capq.push_back(int'(d_out));
   endtask

   task automatic drive(input logic r, input logic v, input logic [19:0] x);
      rst      = r;
      in_valid = v;
      sp       = x;
   endtask

   initial begin
      tbl[0]  = '{20'h00000, 1024};
      tbl[1]  = '{20'h01000, 768};
      tbl[2]  = '{20'hFF000, 768};
      tbl[3]  = '{20'h02000, 448};
      tbl[4]  = '{20'h04000, 124};
      tbl[5]  = '{20'hFC000, 124};
      tbl[6]  = '{20'h05000, 0};
      tbl[7]  = '{20'hF8000, 0};
      tbl[8]  = '{20'h80000, 0};
      tbl[9]  = '{20'h7FFFF, 0};
      tbl[10] = '{20'h00FFF, 768};
      tbl[11] = '{20'h025FF, 295};
      tbl[12] = '{20'h02600, 308};
      tbl[13] = '{20'h04FFF, 0};

      // reset state
      drive(1'b1, 1'b1, 20'h00000);
      repeat (3) step();
      check("reset out_valid", int'(out_valid), 0);
      check("reset D_out", int'(d_out), 0);

      // directed table, each vector held for the pipeline latency
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, 1'b1, tbl[i].x);
         repeat (c_lat) step();
         check($sformatf("tbl[%0d] valid", i), int'(out_valid), 1);
         check($sformatf("tbl[%0d] D", i), int'(d_out), tbl[i].d);
      end

      // sweep -32768 .. +258048 in 4096 steps, back to back
      drive(1'b0, 1'b0, 20'h00000);
      repeat (c_lat) step();
      capq.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 72; i++) begin
         drive(1'b0, 1'b1, 20'(32'hFFFF8000 + 32'(i) * 32'h1000));
         step();
      end
      drive(1'b0, 1'b0, 20'h00000);
      repeat (c_lat) step();
      cap_en = 1'b0;
      check("sweep count", capq.size(), 72);
      if (capq.size() == 72) begin
         check("sweep peak", capq[8], 1024);
         for (int i = 0; i < 8; i++)
            check($sformatf("sweep sym %0d", i), capq[i], capq[16 - i]);
         for (int i = 0; i < 72; i++) begin
            if (i <= 3 || i >= 13) check($sformatf("sweep zero %0d", i), capq[i], 0);
            else if (capq[i] > 1024) check($sformatf("sweep range %0d", i), capq[i], 1024);
         end
      end

      // reset mid-stream discards the in-flight and the presented sample
      drive(1'b0, 1'b1, 20'h02000);
      repeat (2) step();
      drive(1'b1, 1'b1, 20'h01000);
      step();
      check("midrst valid", int'(out_valid), 0);
      check("midrst D", int'(d_out), 0);
      drive(1'b0, 1'b1, 20'h00000);
      repeat (c_lat) step();
      check("postrst valid", int'(out_valid), 1);
      check("postrst D", int'(d_out), 1024);

      // gap: D_out holds while in_valid is low
      drive(1'b0, 1'b1, 20'h02000);
      repeat (c_lat) step();
      drive(1'b0, 1'b0, 20'h04000);
      repeat (c_lat - 1) step();
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("gap%0d valid", i), int'(out_valid), 0);
         check($sformatf("gap%0d D", i), int'(d_out), 448);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [19:0] x;
         case ($urandom_range(0, 3))
            0:       x = 20'($urandom);
            1:       x = 20'($urandom_range(0, 24000));
            2:       x = 20'(-int'($urandom_range(0, 24000)));
            default: x = 20'($urandom_range(0, 65535)) ^ {20{$urandom_range(0, 1) == 1}};
         endcase
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), x);
         step();
      end
      drive(1'b0, 1'b0, 20'h00000);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
